cordic_vec_ctrl: RTL
====================

# cordic_vec_ctrl

Sequencing controller for iterative CORDIC vectoring-mode computation that time-multiplexes one shared two's-complement ALU (ADD/SUB/NOP) over the x, y and z updates of every iteration. Accepts a vector (x, y), runs ITERATIONS micro-rotations at three ALU cycles each, and returns the scaled magnitude and the angle. It sits between the top-level start/done interface and the single ALU instance in the CORDIC datapath.

## Interface
- WORD_WIDTH, default `` `WORD_WIDTH `` (16): data/angle width, signed; angles are Q3.13 radians.
- ITERATIONS, default 12, legal range 1..14: number of micro-rotations.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x_in, y_in  in  WORD_WIDTH  signed input vector; captured on the accepted start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; results valid.
- x_out  out  WORD_WIDTH  magnitude × K (K≈1.6468); held until the next accepted start.
- y_out  out  WORD_WIDTH  residual y, near 0; held.
- z_out  out  WORD_WIDTH  angle, Q3.13; held.
- alu_op  out  2  ALU opcode: ADD=0, SUB=1, NOP=2.
- alu_a, alu_b  out  WORD_WIDTH  ALU operands.
- alu_result  in  WORD_WIDTH  combinational ALU result; the ALU is outside this block.

## Operation
- States: IDLE, PRE_X, PRE_Y (macro only), X_UPD, Y_UPD, Z_UPD, DONE.
- IDLE: alu_op=NOP, alu_a=alu_b=0. When start=1, load x←x_in, y←y_in, z←0, i←0. Go to PRE_X if the macro is defined, otherwise go to X_UPD.
- Iteration i: latch d=(y≥0) in X_UPD. sx = x>>>i and sy = y>>>i, both arithmetic shifts.
  - X_UPD: a=x, b=sy, op=ADD if d, else SUB. Write the result to x_tmp. x itself is unchanged.
  - Y_UPD: a=y, b=sx (old x), op=SUB if d, else ADD. Write the result to y, and in the same cycle write x←x_tmp.
  - Z_UPD: a=z, b=ATAN[i], op=ADD if d, else SUB. Write the result to z. If i=ITERATIONS−1, go to DONE. Otherwise i←i+1 and go to X_UPD.
- ATAN ROM (Q3.13), i=0..13: 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1.
- DONE: done=1 and alu_op=NOP for exactly one cycle, then return to IDLE.
- All arithmetic is done in the ALU and wraps modulo 2^WORD_WIDTH. There is no saturation. Inputs with |x|,|y| ≤ 8192 cannot overflow.
- start while busy, including in DONE, is ignored and not queued.
- x_out/y_out/z_out are the x/y/z registers directly. Their values change only during an operation and are final when done=1.

## Timing
- Reset: state IDLE, busy=0, done=0, x/y/z/x_tmp/i=0, x_out=y_out=z_out=0, alu_op=NOP, alu_a=alu_b=0.
- Start accepted at edge E: busy=1 from the cycle after E. X_UPD for i=0 is the first cycle after E, or after PRE_Y when the macro is defined.
- done is high in cycle 3·ITERATIONS+1 after E without the macro, and in cycle 3·ITERATIONS+3 after E with it. busy falls in the following cycle.
- The earliest next start is accepted in the first IDLE cycle after DONE.
- rst mid-operation: on the next edge, everything returns to reset values. No done pulse is produced.
- ALU outputs are driven combinationally from the state and registers. alu_result is registered at the end of the same cycle.

## Configuration
- CORDIC_QUAD_CORR_EN defined: two pre-rotation cycles run on every operation, regardless of the sign of x.
  - PRE_X: if x<0, a=0, b=x, op=SUB, x←result. Otherwise op=NOP.
  - PRE_Y: if x_in<0, a=0, b=y, op=SUB, y←result, and z←+25736 (π) if y_in≥0, else −25736. Otherwise op=NOP.
  - Full ±π angle range.
- Not defined: the PRE states do not exist. Results are correct only for x_in ≥ 0 (|z| ≤ ~1.74 rad). x_in<0 gives an unspecified but deterministic result.

## Test plan
- Reset then idle: all outputs at their reset values, alu_op=2 every cycle, busy=0.
- x_in=8192, y_in=8192, ITERATIONS=12 → done at cycle 37 after the accepted start. z_out=6434±4 and x_out=19079±8. In the first iteration, the ALU sequence is (ADD, 8192, 8192), (SUB, 8192, 8192), (ADD, 0, 6434).
- x_in=0, y_in=8192 → z_out=12868±4, x_out=13491±8, |y_out|≤4.
- Start pulsed again at cycles 5 and 36 of an operation → ignored. Exactly one done pulse; the next start is accepted only after busy=0.
- rst asserted at cycle 10 of an operation → the next cycle shows all outputs at reset values and no done pulse. A fresh start then completes normally.
- CORDIC_QUAD_CORR_EN, x_in=−8192, y_in=0 → done at cycle 39, z_out=25736±4, x_out=13491±8. With x_in=8192, y_in=0 → z_out=0±4, with the same latency.

Source files
------------

// File: rtl/cordic_vec_ctrl.sv
// cordic_vec_ctrl
// Sequencing controller for iterative CORDIC vectoring. It drives one shared,
// external combinational ALU (ADD/SUB/NOP). Each micro-rotation uses three ALU
// cycles, in the order x, y, z. The block returns the scaled magnitude and the
// angle (Q3.13 radians).
//
// Optional feature: define CORDIC_QUAD_CORR_EN to add the PRE_X/PRE_Y
// pre-rotation. This gives the full +/-pi angle range.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request, sampled only in IDLE
//   x_in, y_in      signed input vector, captured on the accepted start
//   busy            high whenever the FSM is not IDLE
//   done            one-cycle pulse, results valid
//   x_out/y_out/z_out  x/y/z registers, held until the next accepted start
//   alu_op          0=ADD 1=SUB 2=NOP
//   alu_a, alu_b    ALU operands (combinational from state and registers)
//   alu_result      combinational ALU result, registered in the same cycle
//
// Handshake: start is accepted on any rising edge where the FSM is IDLE and
// start=1. While busy (including the DONE cycle) start is ignored and is not
// queued. done is high for exactly the one cycle in which the results are
// final.

`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module cordic_vec_ctrl #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int ITERATIONS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] x_in,
  input  logic [WORD_WIDTH-1:0] y_in,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] x_out,
  output logic [WORD_WIDTH-1:0] y_out,
  output logic [WORD_WIDTH-1:0] z_out,
  output logic [1:0]            alu_op,
  output logic [WORD_WIDTH-1:0] alu_a,
  output logic [WORD_WIDTH-1:0] alu_b,
  input  logic [WORD_WIDTH-1:0] alu_result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef CORDIC_QUAD_CORR_EN
  localparam logic [2:0] S_PRE_X = 3'd1;
  localparam logic [2:0] S_PRE_Y = 3'd2;
  localparam logic signed [WORD_WIDTH-1:0] PI_Q   = WORD_WIDTH'(25736);
  localparam logic signed [WORD_WIDTH-1:0] NEG_PI = -PI_Q;
`endif
  localparam logic [2:0] S_X_UPD = 3'd3;
  localparam logic [2:0] S_Y_UPD = 3'd4;
  localparam logic [2:0] S_Z_UPD = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_NOP = 2'd2;

  localparam logic [3:0] LAST_I = 4'(ITERATIONS - 1);

  logic [2:0]                   state;
  logic signed [WORD_WIDTH-1:0] x_r, y_r, z_r, x_tmp;
  logic [3:0]                   i_r;
  logic                         d_r;
  logic                         dir;
  logic signed [WORD_WIDTH-1:0] sx, sy;
`ifdef CORDIC_QUAD_CORR_EN
  logic                         x_neg;   // x_in < 0 at the accepted start
  logic                         y_pos;   // y_in >= 0 at the accepted start
`endif

  function automatic logic signed [WORD_WIDTH-1:0] atan_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    return WORD_WIDTH'(6434);
      4'd1:    return WORD_WIDTH'(3798);
      4'd2:    return WORD_WIDTH'(2007);
      4'd3:    return WORD_WIDTH'(1019);
      4'd4:    return WORD_WIDTH'(511);
      4'd5:    return WORD_WIDTH'(256);
      4'd6:    return WORD_WIDTH'(128);
      4'd7:    return WORD_WIDTH'(64);
      4'd8:    return WORD_WIDTH'(32);
      4'd9:    return WORD_WIDTH'(16);
      4'd10:   return WORD_WIDTH'(8);
      4'd11:   return WORD_WIDTH'(4);
      4'd12:   return WORD_WIDTH'(2);
      4'd13:   return WORD_WIDTH'(1);
      default: return '0;
    endcase
  endfunction

  // The direction is decided from the live y in X_UPD. It is then held in d_r
  // so that Y_UPD and Z_UPD use the same decision after y has been rewritten.
  assign dir = (state == S_X_UPD) ? ~y_r[WORD_WIDTH-1] : d_r;
  assign sx  = x_r >>> i_r;
  assign sy  = y_r >>> i_r;

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign x_out = x_r;
  assign y_out = y_r;
  assign z_out = z_r;

  always_comb begin
    alu_op = OP_NOP;
    alu_a  = '0;
    alu_b  = '0;
    case (state)
`ifdef CORDIC_QUAD_CORR_EN
      S_PRE_X: if (x_r[WORD_WIDTH-1]) begin
        alu_op = OP_SUB;
        alu_b  = x_r;
      end
      S_PRE_Y: if (x_neg) begin
        alu_op = OP_SUB;
        alu_b  = y_r;
      end
`endif
      S_X_UPD: begin
        alu_op = dir ? OP_ADD : OP_SUB;
        alu_a  = x_r;
        alu_b  = sy;
      end
      S_Y_UPD: begin
        alu_op = dir ? OP_SUB : OP_ADD;
        alu_a  = y_r;
        alu_b  = sx;
      end
      S_Z_UPD: begin
        alu_op = dir ? OP_ADD : OP_SUB;
        alu_a  = z_r;
        alu_b  = atan_rom(i_r);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      x_tmp <= '0;
      i_r   <= '0;
      d_r   <= 1'b0;
`ifdef CORDIC_QUAD_CORR_EN
      x_neg <= 1'b0;
      y_pos <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          x_r <= x_in;
          y_r <= y_in;
          z_r <= '0;
          i_r <= '0;
`ifdef CORDIC_QUAD_CORR_EN
          x_neg <= x_in[WORD_WIDTH-1];
          y_pos <= ~y_in[WORD_WIDTH-1];
          state <= S_PRE_X;
`else
          state <= S_X_UPD;
`endif
        end
`ifdef CORDIC_QUAD_CORR_EN
        S_PRE_X: begin
          if (x_r[WORD_WIDTH-1]) x_r <= alu_result;
          state <= S_PRE_Y;
        end
        S_PRE_Y: begin
          // The quadrant decision uses the captured input signs, because x
          // has already been negated in PRE_X.
          if (x_neg) begin
            y_r <= alu_result;
            z_r <= y_pos ? PI_Q : NEG_PI;
          end
          state <= S_X_UPD;
        end
`endif
        S_X_UPD: begin
          // x must stay unchanged until Y_UPD has consumed the old x>>>i.
          x_tmp <= alu_result;
          d_r   <= dir;
          state <= S_Y_UPD;
        end
        S_Y_UPD: begin
          y_r   <= alu_result;
          x_r   <= x_tmp;
          state <= S_Z_UPD;
        end
        S_Z_UPD: begin
          z_r <= alu_result;
          if (i_r == LAST_I) begin
            state <= S_DONE;
          end else begin
            i_r   <= i_r + 4'd1;
            state <= S_X_UPD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
